// File: rtl/tlb_pkg.sv
// Shared types for the associative TLB: FSM states, entry layout, victim choice.
package tlb_pkg;

  // Entry fields are sized for the widest supported configuration; instances
  // zero-extend narrower VPN/PPN/ASID values into them.
  localparam int unsigned TLB_MAX_VPN_W  = 52;
  localparam int unsigned TLB_MAX_PPN_W  = 52;
  localparam int unsigned TLB_MAX_ASID_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    FAULT
  } tlb_state_e;

  typedef struct packed {
    logic                      valid;
    logic [TLB_MAX_VPN_W-1:0]  vpn;
    logic [TLB_MAX_ASID_W-1:0] asid;
    logic [TLB_MAX_PPN_W-1:0]  ppn;
    logic                      writable;
  } tlb_entry_t;

  // Prefer a free slot; fall back to the round-robin pointer.
  function automatic int unsigned tlb_victim(input logic        free_found,
                                             input int unsigned free_idx,
                                             input int unsigned rr_idx);
    return free_found ? free_idx : rr_idx;
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// Entry array with parallel VPN/ASID match, first-free search, fill and flush.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned VPN_WIDTH   = 20,
  parameter int unsigned PPN_WIDTH   = 8,
  parameter int unsigned ASID_WIDTH  = 4,
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [VPN_WIDTH-1:0]  lk_vpn_i,
  input  logic [ASID_WIDTH-1:0] lk_asid_i,
  output logic                  hit_o,
  output logic [PPN_WIDTH-1:0]  hit_ppn_o,
  output logic                  hit_writable_o,
  output logic                  free_found_o,
  output logic [IDX_WIDTH-1:0]  free_idx_o,
  input  logic                  wr_en_i,
  input  logic [IDX_WIDTH-1:0]  wr_idx_i,
  input  logic [VPN_WIDTH-1:0]  wr_vpn_i,
  input  logic [ASID_WIDTH-1:0] wr_asid_i,
  input  logic [PPN_WIDTH-1:0]  wr_ppn_i,
  input  logic                  wr_writable_i,
  input  logic                  flush_all_i,
  input  logic                  flush_asid_i
);

  tlb_entry_t                  entries_q [NUM_ENTRIES];
  tlb_entry_t                  wr_entry;
  logic [TLB_MAX_VPN_W-1:0]    lk_vpn_ext;
  logic [TLB_MAX_ASID_W-1:0]   lk_asid_ext;
  logic [IDX_WIDTH-1:0]        hit_idx;

  assign lk_vpn_ext  = TLB_MAX_VPN_W'(lk_vpn_i);
  assign lk_asid_ext = TLB_MAX_ASID_W'(lk_asid_i);

  assign wr_entry = '{valid:    1'b1,
                      vpn:      TLB_MAX_VPN_W'(wr_vpn_i),
                      asid:     TLB_MAX_ASID_W'(wr_asid_i),
                      ppn:      TLB_MAX_PPN_W'(wr_ppn_i),
                      writable: wr_writable_i};

  // Parallel match (at most one hit, so index bits are OR-combined) and lowest free slot.
  always_comb begin
    hit_o        = 1'b0;
    hit_idx      = '0;
    free_found_o = 1'b0;
    free_idx_o   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (entries_q[i].valid && entries_q[i].vpn == lk_vpn_ext &&
          entries_q[i].asid == lk_asid_ext) begin
        hit_o   = 1'b1;
        hit_idx = hit_idx | IDX_WIDTH'(i);
      end
      if (!entries_q[i].valid && !free_found_o) begin
        free_found_o = 1'b1;
        free_idx_o   = IDX_WIDTH'(i);
      end
    end
  end

  assign hit_ppn_o      = PPN_WIDTH'(entries_q[hit_idx].ppn);
  assign hit_writable_o = entries_q[hit_idx].writable;

  // Fill and flush; a flush on the same edge overrides the written valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) entries_q[i].valid <= 1'b0;
    end else begin
      if (wr_en_i) entries_q[wr_idx_i] <= wr_entry;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (flush_all_i || (flush_asid_i && entries_q[i].asid == lk_asid_ext))
          entries_q[i].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tlb_assoc.sv
// Fully associative TLB: lookup, miss FSM with level-held PTW handshake, replacement.
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int unsigned VA_WIDTH          = 32,
  parameter int unsigned PA_WIDTH          = 20,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned NUM_ENTRIES       = 16,
  parameter int unsigned ASID_WIDTH        = 4,
  localparam int unsigned VPN_WIDTH        = VA_WIDTH - PAGE_OFFSET_WIDTH,
  localparam int unsigned PPN_WIDTH        = PA_WIDTH - PAGE_OFFSET_WIDTH,
  localparam int unsigned IDX_WIDTH        = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  admin,
  input  logic                  req_valid,
  input  logic [VA_WIDTH-1:0]   req_va,
  input  logic [ASID_WIDTH-1:0] req_asid,
  input  logic                  req_write,
  output logic [PA_WIDTH-1:0]   pa,
  output logic                  stall,
  output logic                  fault,
  input  logic                  flush_all,
  input  logic                  flush_asid,
  output logic                  ptw_req,
  output logic [VPN_WIDTH-1:0]  ptw_vpn,
  output logic [ASID_WIDTH-1:0] ptw_asid,
  input  logic                  ptw_valid,
  input  logic [PPN_WIDTH-1:0]  ptw_ppn,
  input  logic                  ptw_writable,
  input  logic                  ptw_fault
);

  tlb_state_e             state_q, state_d;
  logic                   drop_q, drop_d;
  logic [IDX_WIDTH-1:0]   rr_q, rr_d;
  logic [VPN_WIDTH-1:0]   vpn_q, vpn_d;
  logic [ASID_WIDTH-1:0]  asid_q, asid_d;

  logic                   hit, hit_writable, free_found, fill, flush;
  logic [PPN_WIDTH-1:0]   hit_ppn;
  logic [IDX_WIDTH-1:0]   free_idx, victim;

  assign flush  = flush_all | flush_asid;
  assign victim = IDX_WIDTH'(tlb_victim(free_found, 32'(free_idx), 32'(rr_q)));

  tlb_cam #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VPN_WIDTH   (VPN_WIDTH),
    .PPN_WIDTH   (PPN_WIDTH),
    .ASID_WIDTH  (ASID_WIDTH)
  ) u_cam (
    .clk_i          (clk),
    .rst_i          (rst),
    .lk_vpn_i       (req_va[VA_WIDTH-1:PAGE_OFFSET_WIDTH]),
    .lk_asid_i      (req_asid),
    .hit_o          (hit),
    .hit_ppn_o      (hit_ppn),
    .hit_writable_o (hit_writable),
    .free_found_o   (free_found),
    .free_idx_o     (free_idx),
    .wr_en_i        (fill),
    .wr_idx_i       (victim),
    .wr_vpn_i       (vpn_q),
    .wr_asid_i      (asid_q),
    .wr_ppn_i       (ptw_ppn),
    .wr_writable_i  (ptw_writable),
    .flush_all_i    (flush_all),
    .flush_asid_i   (flush_asid)
  );

  // State, walk latches, drop flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      rr_q    <= '0;
      vpn_q   <= '0;
      asid_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      rr_q    <= rr_d;
      vpn_q   <= vpn_d;
      asid_q  <= asid_d;
    end
  end

  // Next-state and translation outputs.
  always_comb begin
    state_d = state_q;
    vpn_d   = vpn_q;
    asid_d  = asid_q;
    rr_d    = rr_q;
    fill    = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    pa      = admin ? req_va[PA_WIDTH-1:0] : '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !admin) begin
          if (hit) begin
            if (req_write && !hit_writable) fault = 1'b1;
            else pa = {hit_ppn, req_va[PAGE_OFFSET_WIDTH-1:0]};
          end else begin
            stall   = 1'b1;
            vpn_d   = req_va[VA_WIDTH-1:PAGE_OFFSET_WIDTH];
            asid_d  = req_asid;
            state_d = WALK;
          end
        end
      end
      WALK: begin
        stall = !admin;
        if (ptw_valid) begin
          if (ptw_fault) begin
            state_d = FAULT;
          end else begin
            fill    = !drop_q && !flush;
            state_d = IDLE;
          end
        end
      end
      FAULT: begin
        fault   = !admin;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fill && !free_found) rr_d = rr_q + 1'b1;
    // Drop flag lives only for the walk in which a flush was seen.
    drop_d = (state_d == WALK) && (drop_q || (state_q == WALK && flush));
  end

  assign ptw_req  = (state_q == WALK);
  assign ptw_vpn  = vpn_q;
  assign ptw_asid = asid_q;

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed self-checking bench for tlb_assoc.
module tb_tlb_assoc;

  logic        clk = 1'b0;
  logic        rst, admin, req_valid, req_write;
  logic [31:0] req_va;
  logic [3:0]  req_asid;
  logic [19:0] pa;
  logic        stall, fault, flush_all, flush_asid;
  logic        ptw_req, ptw_valid, ptw_writable, ptw_fault;
  logic [19:0] ptw_vpn;
  logic [3:0]  ptw_asid;
  logic [7:0]  ptw_ppn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tlb_assoc #(
    .VA_WIDTH          (32),
    .PA_WIDTH          (20),
    .PAGE_OFFSET_WIDTH (12),
    .NUM_ENTRIES       (16),
    .ASID_WIDTH        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .admin        (admin),
    .req_valid    (req_valid),
    .req_va       (req_va),
    .req_asid     (req_asid),
    .req_write    (req_write),
    .pa           (pa),
    .stall        (stall),
    .fault        (fault),
    .flush_all    (flush_all),
    .flush_asid   (flush_asid),
    .ptw_req      (ptw_req),
    .ptw_vpn      (ptw_vpn),
    .ptw_asid     (ptw_asid),
    .ptw_valid    (ptw_valid),
    .ptw_ppn      (ptw_ppn),
    .ptw_writable (ptw_writable),
    .ptw_fault    (ptw_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pa_of(input logic [7:0] ppn, input logic [31:0] va);
    return {12'h0, ppn, va[11:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; ptw_valid = 1'b0; flush_all = 1'b0; flush_asid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic probe(input logic [31:0] va, input logic [3:0] asid, input logic wr);
    @(negedge clk);
    req_valid = 1'b1; req_va = va; req_asid = asid; req_write = wr;
    #1;
  endtask

  // Full miss-and-fill with a one-cycle PTW response.
  task automatic fill(input logic [31:0] va, input logic [3:0] asid,
                      input logic [7:0] ppn, input logic wr);
    probe(va, asid, 1'b0);
    chk("fill_miss_stall", {31'b0, stall}, 1);
    @(negedge clk); #1;
    chk("fill_ptw_req", {31'b0, ptw_req}, 1);
    chk("fill_ptw_vpn", {12'b0, ptw_vpn}, {12'b0, va[31:12]});
    chk("fill_ptw_asid", {28'b0, ptw_asid}, {28'b0, asid});
    chk("fill_walk_stall", {31'b0, stall}, 1);
    ptw_valid = 1'b1; ptw_ppn = ppn; ptw_writable = wr; ptw_fault = 1'b0;
    @(negedge clk);
    ptw_valid = 1'b0; #1;
    chk("fill_hit_stall", {31'b0, stall}, 0);
    chk("fill_hit_pa", {12'b0, pa}, pa_of(ppn, va));
    req_valid = 1'b0;
  endtask

  // From a cycle just before WALK: end the walk with a page fault, no fill.
  task automatic abort_walk();
    @(negedge clk);
    req_valid = 1'b0; ptw_valid = 1'b1; ptw_fault = 1'b1;
    @(negedge clk);
    ptw_valid = 1'b0; ptw_fault = 1'b0; #1;
    chk("abort_fault", {31'b0, fault}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; admin = 1'b0; req_valid = 1'b0; req_va = '0; req_asid = '0; req_write = 1'b0;
    flush_all = 1'b0; flush_asid = 1'b0; ptw_valid = 1'b0; ptw_ppn = '0;
    ptw_writable = 1'b0; ptw_fault = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_pa", {12'b0, pa}, 0);
    chk("rst_ptw_req", {31'b0, ptw_req}, 0);
    chk("rst_ptw_vpn", {12'b0, ptw_vpn}, 0);
    chk("rst_ptw_asid", {28'b0, ptw_asid}, 0);
    rst = 1'b0;

    // Cold miss
    fill(32'h0000_5123, 4'd1, 8'h42, 1'b1);

    // ASID isolation
    fill(32'h0000_5123, 4'd2, 8'h55, 1'b1);
    probe(32'h0000_5123, 4'd1, 1'b0);
    chk("asid1_pa", {12'b0, pa}, 32'h42123);
    chk("asid1_stall", {31'b0, stall}, 0);
    probe(32'h0000_5123, 4'd2, 1'b0);
    chk("asid2_pa", {12'b0, pa}, 32'h55123);

    // Permission fault on store to read-only page
    fill(32'h0000_7abc, 4'd1, 8'h10, 1'b0);
    probe(32'h0000_7abc, 4'd1, 1'b1);
    chk("perm_fault", {31'b0, fault}, 1);
    chk("perm_stall", {31'b0, stall}, 0);
    probe(32'h0000_7abc, 4'd1, 1'b0);
    chk("perm_no_walk", {31'b0, ptw_req}, 0);
    chk("perm_load_pa", {12'b0, pa}, 32'h10abc);
    chk("perm_load_fault", {31'b0, fault}, 0);

    // Walk fault: one FAULT cycle, no fill, then misses again
    probe(32'h0000_9000, 4'd1, 1'b0);
    chk("wf_stall", {31'b0, stall}, 1);
    @(negedge clk); #1;
    chk("wf_ptw_req", {31'b0, ptw_req}, 1);
    ptw_valid = 1'b1; ptw_fault = 1'b1;
    @(negedge clk);
    ptw_valid = 1'b0; ptw_fault = 1'b0; #1;
    chk("wf_fault", {31'b0, fault}, 1);
    chk("wf_fault_stall", {31'b0, stall}, 0);
    chk("wf_fault_pa", {12'b0, pa}, 0);
    @(negedge clk); #1;
    chk("wf_fault_done", {31'b0, fault}, 0);
    chk("wf_remiss", {31'b0, stall}, 1);
    abort_walk();

    // Replacement: 16 fills into free slots, 17th evicts entry 0
    do_reset();
    for (int i = 0; i < 17; i++)
      fill(32'(((32'h100 + i) << 12) | 32'h123), 4'd3, 8'(8'h20 + i), 1'b1);
    for (int i = 1; i < 17; i++) begin
      probe(32'(((32'h100 + i) << 12) | 32'h123), 4'd3, 1'b0);
      chk("repl_hit_stall", {31'b0, stall}, 0);
      chk("repl_hit_pa", {12'b0, pa}, {12'b0, 8'(8'h20 + i), 12'h123});
    end
    probe(32'h0010_0123, 4'd3, 1'b0);
    chk("repl_evicted_miss", {31'b0, stall}, 1);
    abort_walk();

    // Flush racing ptw_valid: flush wins
    do_reset();
    fill(32'h0020_0123, 4'd4, 8'h30, 1'b1);
    probe(32'h0020_1123, 4'd4, 1'b0);
    chk("race_miss", {31'b0, stall}, 1);
    @(negedge clk);
    ptw_valid = 1'b1; ptw_ppn = 8'h31; ptw_fault = 1'b0; flush_all = 1'b1;
    @(negedge clk);
    ptw_valid = 1'b0; flush_all = 1'b0; #1;
    chk("race_no_fill", {31'b0, stall}, 1);
    abort_walk();
    probe(32'h0020_0123, 4'd4, 1'b0);
    chk("race_old_flushed", {31'b0, stall}, 1);
    abort_walk();

    // flush_asid mid-walk: walk result dropped, other ASID survives
    do_reset();
    fill(32'h0030_0123, 4'd5, 8'h60, 1'b1);
    fill(32'h0030_0123, 4'd6, 8'h61, 1'b1);
    probe(32'h0030_1123, 4'd6, 1'b0);
    chk("fa_miss", {31'b0, stall}, 1);
    @(negedge clk);
    flush_asid = 1'b1;
    @(negedge clk);
    flush_asid = 1'b0; ptw_valid = 1'b1; ptw_ppn = 8'h77; ptw_fault = 1'b0;
    @(negedge clk);
    ptw_valid = 1'b0; #1;
    chk("fa_dropped", {31'b0, stall}, 1);
    abort_walk();
    probe(32'h0030_0123, 4'd5, 1'b0);
    chk("fa_other_stall", {31'b0, stall}, 0);
    chk("fa_other_pa", {12'b0, pa}, 32'h60123);
    probe(32'h0030_0123, 4'd6, 1'b0);
    chk("fa_same_flushed", {31'b0, stall}, 1);
    abort_walk();

    // Admin bypass
    admin = 1'b1;
    probe(32'hDEAD_BEEF, 4'd1, 1'b1);
    chk("admin_pa", {12'b0, pa}, 32'hDBEEF);
    chk("admin_stall", {31'b0, stall}, 0);
    chk("admin_fault", {31'b0, fault}, 0);
    @(negedge clk); #1;
    chk("admin_no_walk", {31'b0, ptw_req}, 0);
    admin = 1'b0; req_valid = 1'b0;

    // Reset mid-walk; late PTW response ignored
    probe(32'h0040_0123, 4'd1, 1'b0);
    chk("rw_miss", {31'b0, stall}, 1);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rw_ptw_req", {31'b0, ptw_req}, 0);
    chk("rw_ptw_vpn", {12'b0, ptw_vpn}, 0);
    ptw_valid = 1'b1; ptw_ppn = 8'h44; ptw_fault = 1'b0;
    @(negedge clk);
    ptw_valid = 1'b0;
    probe(32'h0040_0123, 4'd1, 1'b0);
    chk("rw_not_filled", {31'b0, stall}, 1);
    abort_walk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
